// File: rtl/sram_pkg.sv
// Shared types and helpers for the two-port column-enable SRAM model.
package sram_pkg;

   typedef enum logic {SRAM_CLR, SRAM_RUN} sram_state_t;

   localparam int SRAM_RD_LAT_MIN = 1;
   localparam int SRAM_RD_LAT_MAX = 2;
   // Widest word col_merge can handle; callers zero-extend into this width.
   localparam int SRAM_MAX_DW     = 256;

   // Per-column select: bit i comes from nw_w when its column's mask bit is set.
   function automatic logic [SRAM_MAX_DW-1:0] col_merge(
      input logic [SRAM_MAX_DW-1:0] old_w,
      input logic [SRAM_MAX_DW-1:0] nw_w,
      input logic [SRAM_MAX_DW-1:0] mask,
      input int                     col_wd
   );
      logic [SRAM_MAX_DW-1:0] r;
      for (int i = 0; i < SRAM_MAX_DW; i++)
         r[i] = mask[i / col_wd] ? nw_w[i] : old_w[i];
      return r;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output pipeline: carries the {val,dat} pair through RD_LAT registers.
module sram_rd_pipe
   import sram_pkg::*;
#(
   parameter int DAT_WD = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_val,
   input  logic [DAT_WD-1:0] in_dat,
   output logic              out_val,
   output logic [DAT_WD-1:0] out_dat
);

   if (RD_LAT < SRAM_RD_LAT_MIN || RD_LAT > SRAM_RD_LAT_MAX) begin : g_bad_lat
      $fatal(1, "sram_rd_pipe: RD_LAT must be 1 or 2");
   end

   logic              val0;
   logic [DAT_WD-1:0] dat0;

   // Data registers only load on a valid beat so rd_dat holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         val0 <= 1'b0;
         dat0 <= '0;
      end else begin
         val0 <= in_val;
         if (in_val) dat0 <= in_dat;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              val1;
      logic [DAT_WD-1:0] dat1;

      always_ff @(posedge clk) begin
         if (rst) begin
            val1 <= 1'b0;
            dat1 <= '0;
         end else begin
            val1 <= val0;
            if (val0) dat1 <= dat0;
         end
      end

      assign out_val = val1;
      assign out_dat = dat1;
   end else begin : g_lat1
      assign out_val = val0;
      assign out_dat = dat0;
   end

endmodule

// File: rtl/sram_tp_be_clr.sv
// Two-port SRAM with per-column write enables, read-during-write bypass,
// configurable read latency and a post-reset clear sweep.
module sram_tp_be_clr
   import sram_pkg::*;
#(
   parameter int ADR_WD     = 6,
   parameter int DAT_WD     = 32,
   parameter int COL_WD     = 8,
   parameter int RD_LAT     = 1,
   parameter int BYPASS     = 1,
   parameter int CLR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_ena,
   input  logic [DAT_WD/COL_WD-1:0] wr_col,
   input  logic [ADR_WD-1:0]        wr_adr,
   input  logic [DAT_WD-1:0]        wr_dat,
   input  logic                     rd_ena,
   input  logic [ADR_WD-1:0]        rd_adr,
   output logic [DAT_WD-1:0]        rd_dat,
   output logic                     rd_val,
   output logic                     init_busy
);

   localparam int DEPTH   = 2 ** ADR_WD;
   localparam int COL_NUM = DAT_WD / COL_WD;

   if (DAT_WD % COL_WD != 0) begin : g_bad_col
      $fatal(1, "sram_tp_be_clr: DAT_WD must be a multiple of COL_WD");
   end
   if (RD_LAT < SRAM_RD_LAT_MIN || RD_LAT > SRAM_RD_LAT_MAX) begin : g_bad_lat
      $fatal(1, "sram_tp_be_clr: RD_LAT must be 1 or 2");
   end
   if (DAT_WD > SRAM_MAX_DW) begin : g_bad_dw
      $fatal(1, "sram_tp_be_clr: DAT_WD exceeds SRAM_MAX_DW");
   end

   logic [DAT_WD-1:0] mem [DEPTH];
   sram_state_t       state;
   logic [ADR_WD-1:0] clr_cnt;

   logic clr_go, wr_go, rd_go, collide;
   assign clr_go  = (state == SRAM_CLR) && !rst;
   assign wr_go   = (state == SRAM_RUN) && !rst && wr_ena;
   assign rd_go   = (state == SRAM_RUN) && !rst && rd_ena;
   assign collide = (BYPASS != 0) && wr_go && (wr_adr == rd_adr);

   // Widen operands so the shared package merge serves any DAT_WD.
   logic [SRAM_MAX_DW-1:0] wr_old_x, rd_old_x, new_x, msk_x, mrg_wr_x, mrg_rd_x;
   logic [DAT_WD-1:0]      wr_word, rd_word;

   always_comb begin
      wr_old_x = '0;
      rd_old_x = '0;
      new_x    = '0;
      msk_x    = '0;
      wr_old_x[DAT_WD-1:0]  = mem[wr_adr];
      rd_old_x[DAT_WD-1:0]  = mem[rd_adr];
      new_x[DAT_WD-1:0]     = wr_dat;
      msk_x[COL_NUM-1:0]    = wr_col;
      mrg_wr_x = col_merge(wr_old_x, new_x, msk_x, COL_WD);
      mrg_rd_x = col_merge(rd_old_x, new_x, msk_x, COL_WD);
      wr_word  = mrg_wr_x[DAT_WD-1:0];
      rd_word  = collide ? mrg_rd_x[DAT_WD-1:0] : mem[rd_adr];
   end

   if (DAT_WD < SRAM_MAX_DW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{mrg_wr_x[SRAM_MAX_DW-1:DAT_WD], mrg_rd_x[SRAM_MAX_DW-1:DAT_WD]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (CLR_ON_RST != 0) ? SRAM_CLR : SRAM_RUN;
         clr_cnt   <= '0;
         init_busy <= (CLR_ON_RST != 0);
      end else if (state == SRAM_CLR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (&clr_cnt) begin
            state     <= SRAM_RUN;
            init_busy <= 1'b0;
         end
      end
   end

   // The sweep owns the array until it completes; user writes are dropped.
   always_ff @(posedge clk) begin
      if (clr_go)
         mem[clr_cnt] <= '0;
      else if (wr_go)
         mem[wr_adr] <= wr_word;
   end

   sram_rd_pipe #(
      .DAT_WD (DAT_WD),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_val  (rd_go),
      .in_dat  (rd_word),
      .out_val (rd_val),
      .out_dat (rd_dat)
   );

endmodule

// File: tb/tb_sram_tp_be_clr.sv
// Bench for sram_tp_be_clr: a latency-1 write-first instance and a
// latency-2 read-first instance share stimulus; reads are scoreboarded.
module tb_sram_tp_be_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wr_ena, rd_ena;
   logic [3:0]  wr_col;
   logic [5:0]  wr_adr, rd_adr;
   logic [31:0] wr_dat;
   logic [31:0] rd_dat_a, rd_dat_b;
   logic        rd_val_a, rd_val_b, busy_a, busy_b;

   sram_tp_be_clr #(.ADR_WD(6), .DAT_WD(32), .COL_WD(8), .RD_LAT(1), .BYPASS(1), .CLR_ON_RST(1)) dut_a (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_col(wr_col), .wr_adr(wr_adr), .wr_dat(wr_dat),
      .rd_ena(rd_ena), .rd_adr(rd_adr), .rd_dat(rd_dat_a), .rd_val(rd_val_a), .init_busy(busy_a));

   sram_tp_be_clr #(.ADR_WD(6), .DAT_WD(32), .COL_WD(8), .RD_LAT(2), .BYPASS(0), .CLR_ON_RST(1)) dut_b (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_col(wr_col), .wr_adr(wr_adr), .wr_dat(wr_dat),
      .rd_ena(rd_ena), .rd_adr(rd_adr), .rd_dat(rd_dat_b), .rd_val(rd_val_b), .init_busy(busy_b));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   typedef struct { int due; logic [31:0] dat; } sb_t;
   sb_t qa[$], qb[$];
   sb_t ea, eb;

   typedef struct {
      logic        we;
      logic [3:0]  col;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [5:0]  ra;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: every rd_val pulse must match the head entry in cycle and data.
   always @(negedge clk) begin
      if (rd_val_a === 1'b1) begin
         if (qa.size() == 0) chk("rd_val_a spurious", {31'b0, rd_val_a}, 32'd0);
         else begin
            ea = qa.pop_front();
            chk("rd_val_a cycle", cyc, ea.due);
            chk("rd_dat_a", rd_dat_a, ea.dat);
         end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
         chk("rd_val_a missing", {31'b0, rd_val_a}, 32'd1);
         void'(qa.pop_front());
      end
      if (rd_val_b === 1'b1) begin
         if (qb.size() == 0) chk("rd_val_b spurious", {31'b0, rd_val_b}, 32'd0);
         else begin
            eb = qb.pop_front();
            chk("rd_val_b cycle", cyc, eb.due);
            chk("rd_dat_b", rd_dat_b, eb.dat);
         end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
         chk("rd_val_b missing", {31'b0, rd_val_b}, 32'd1);
         void'(qb.pop_front());
      end
   end

   task automatic set_idle();
      wr_ena = 1'b0; wr_col = 4'h0; wr_adr = 6'd0; wr_dat = 32'h0;
      rd_ena = 1'b0; rd_adr = 6'd0;
   endtask

   // Drives one cycle of stimulus; a read queues its result for both instances.
   task automatic step(vec_t v);
      @(negedge clk);
      wr_ena = v.we; wr_col = v.col; wr_adr = v.wa; wr_dat = v.wd;
      rd_ena = v.re; rd_adr = v.ra;
      if (v.re) begin
         qa.push_back('{due: cyc + 1, dat: v.exp_a});
         qb.push_back('{due: cyc + 2, dat: v.exp_b});
      end
   endtask

   task automatic idle_cycles(int n);
      vec_t v;
      v = '{default: '0};
      repeat (n) step(v);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_a === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got %0d cycles, want fewer", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      vec_t v;

      tbl[0]  = '{1'b1, 4'hF, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,        32'h0};
      tbl[1]  = '{1'b1, 4'h5, 6'd5,  32'h11223344, 1'b0, 6'd0,  32'h0,        32'h0};
      tbl[2]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd5,  32'hDE22BE44, 32'hDE22BE44};
      tbl[3]  = '{1'b1, 4'hF, 6'd9,  32'hAAAAAAAA, 1'b0, 6'd0,  32'h0,        32'h0};
      tbl[4]  = '{1'b1, 4'h3, 6'd9,  32'h55555555, 1'b1, 6'd9,  32'hAAAA5555, 32'hAAAAAAAA};
      tbl[5]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd9,  32'hAAAA5555, 32'hAAAA5555};
      tbl[6]  = '{1'b1, 4'h8, 6'd63, 32'h12345678, 1'b1, 6'd0,  32'h0,        32'h0};
      tbl[7]  = '{1'b1, 4'h0, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd63, 32'h12000000, 32'h12000000};
      tbl[8]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd0,  32'h0,        32'h0};
      tbl[9]  = '{1'b1, 4'hF, 6'd1,  32'h01010101, 1'b1, 6'd1,  32'h01010101, 32'h0};
      tbl[10] = '{1'b1, 4'hF, 6'd2,  32'h02020202, 1'b0, 6'd0,  32'h0,        32'h0};
      tbl[11] = '{1'b1, 4'hF, 6'd3,  32'h03030303, 1'b0, 6'd0,  32'h0,        32'h0};
      tbl[12] = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd1,  32'h01010101, 32'h01010101};
      tbl[13] = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd2,  32'h02020202, 32'h02020202};
      tbl[14] = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd3,  32'h03030303, 32'h03030303};

      // One-cycle reset, then the clear sweep must last exactly DEPTH cycles.
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset init_busy_a", {31'b0, busy_a}, 32'd1);
      chk("reset init_busy_b", {31'b0, busy_b}, 32'd1);
      chk("reset rd_val_a", {31'b0, rd_val_a}, 32'd0);
      chk("reset rd_val_b", {31'b0, rd_val_b}, 32'd0);
      chk("reset rd_dat_a", rd_dat_a, 32'h0);
      chk("reset rd_dat_b", rd_dat_b, 32'h0);
      count_busy(n);
      chk("init_busy length", n, 32'd64);
      chk("init_busy_b after sweep", {31'b0, busy_b}, 32'd0);

      for (int i = 0; i < 64; i++) begin
         v = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(i), 32'h0, 32'h0};
         step(v);
      end

      for (int i = 0; i < 15; i++) step(tbl[i]);
      idle_cycles(6);
      chk("rd_dat_a hold", rd_dat_a, 32'h03030303);
      chk("rd_dat_b hold", rd_dat_b, 32'h03030303);
      chk("queue a drained", qa.size(), 32'd0);
      chk("queue b drained", qb.size(), 32'd0);

      // Reset again mid-sweep; a write and read during the restarted sweep are dropped.
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (busy_a === 1'b1 && n < 200) begin
         if (n == 20) begin
            wr_ena = 1'b1; wr_col = 4'hF; wr_adr = 6'd3; wr_dat = 32'hBADC0DE5;
            rd_ena = 1'b1; rd_adr = 6'd3;
         end else set_idle();
         n++;
         @(negedge clk);
      end
      set_idle();
      chk("restart init_busy length", n, 32'd64);
      v = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd3, 32'h0, 32'h0};
      step(v);
      v = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9, 32'h0, 32'h0};
      step(v);
      idle_cycles(3);

      // Reset lands while a latency-2 read is in flight.
      v = '{1'b1, 4'hF, 6'd4, 32'hCAFEF00D, 1'b0, 6'd0, 32'h0, 32'h0};
      step(v);
      v = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd4, 32'hCAFEF00D, 32'hCAFEF00D};
      step(v);
      idle_cycles(3);
      @(negedge clk);
      set_idle();
      rd_ena = 1'b1; rd_adr = 6'd4;
      qa.push_back('{due: cyc + 1, dat: 32'hCAFEF00D});
      @(negedge clk);
      rd_ena = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("inflight rst rd_val_b", {31'b0, rd_val_b}, 32'd0);
      chk("inflight rst rd_dat_b", rd_dat_b, 32'h0);
      chk("inflight rst rd_val_a", {31'b0, rd_val_a}, 32'd0);
      chk("inflight rst rd_dat_a", rd_dat_a, 32'h0);
      count_busy(n);
      chk("post-rst init_busy length", n, 32'd64);
      idle_cycles(5);
      chk("final queue a", qa.size(), 32'd0);
      chk("final queue b", qb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
